// File: rtl/dd_pkg.sv
// Shared widths, types and FSM encoding for the weight-RAM sweep reader.
package dd_pkg;

  localparam int DATA_W  = 10;
  localparam int ADDR_W  = 7;
  localparam int N_WORDS = 65;
  // Full signed product plus enough headroom for N_WORDS additions.
  localparam int ACC_W   = 2 * DATA_W + $clog2(N_WORDS);
  localparam int PROD_W  = 2 * DATA_W;

  typedef logic signed [DATA_W-1:0] weight_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate with synchronous clear; sum_next exposes the
// accumulator value including the product currently on the inputs.
module mac_unit
  import dd_pkg::*;
(
  input  logic    clk,
  input  logic    srst,
  input  logic    clear,
  input  logic    en,
  input  weight_t a,
  input  weight_t b,
  output acc_t    sum_next
);

  prod_t prod;
  acc_t  acc_reg;

  // Widen before multiplying so the full signed product is kept.
  assign prod     = prod_t'(a) * prod_t'(b);
  assign sum_next = acc_reg + acc_t'(prod);

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= sum_next;
    end
  end

endmodule

// File: rtl/weight_sweep_reader.sv
// Sweeps the weight RAM and feature buffer once per start and emits the signed
// dot product. Define WEIGHT_SWEEP_RELU_EN to clamp negative results to zero.
module weight_sweep_reader
  import dd_pkg::*;
(
  input  logic              Clock,
  input  logic              Rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ramAddr,
  output logic              ramRe,
  input  weight_t           ramData,
  output logic [ADDR_W-1:0] featAddr,
  input  weight_t           featData,
  output logic              busy,
  output logic              done,
  output acc_t              result
);

  localparam logic [ADDR_W-1:0] PENULT_ADDR = ADDR_W'(N_WORDS - 2);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              re_reg;
  logic              valid_reg;
  logic              busy_reg;
  logic              done_reg;
  acc_t              result_reg;
  acc_t              sum_next;
  logic              sweep_go;

  function automatic acc_t finalize(acc_t s);
`ifdef WEIGHT_SWEEP_RELU_EN
    return s[ACC_W-1] ? '0 : s;
`else
    return s;
`endif
  endfunction

  assign sweep_go = (state_reg == IDLE) && start;

  mac_unit u_mac (
    .clk      (Clock),
    .srst     (Rst),
    .clear    (sweep_go),
    .en       (valid_reg),
    .a        (ramData),
    .b        (featData),
    .sum_next (sum_next)
  );

  // FETCH issues addresses 0..N-2, DRAIN issues the last one, DONE waits for
  // its data and folds it straight into the registered result.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      re_reg     <= 1'b0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      done_reg  <= 1'b0;
      valid_reg <= re_reg;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= FETCH;
            addr_reg  <= '0;
            re_reg    <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        FETCH: begin
          addr_reg <= addr_reg + ADDR_W'(1);
          if (addr_reg == PENULT_ADDR) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          re_reg    <= 1'b0;
          state_reg <= DONE;
        end
        DONE: begin
          result_reg <= finalize(sum_next);
          done_reg   <= 1'b1;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ramAddr  = addr_reg;
  assign featAddr = addr_reg;
  assign ramRe    = re_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign result   = result_reg;

endmodule

// File: tb/tb_weight_sweep_reader.sv
// Self-checking bench: table vectors, randomized sweeps against a dot-product
// model, and hand-written sequences for restart, reset and held-start cases.
module tb_weight_sweep_reader;
  import dd_pkg::*;

  logic              Clock = 1'b0;
  logic              Rst;
  logic              start;
  logic [ADDR_W-1:0] ramAddr;
  logic [ADDR_W-1:0] featAddr;
  logic              ramRe;
  logic              busy;
  logic              done;
  weight_t           ramData;
  weight_t           featData;
  acc_t              result;

  always #5 Clock = ~Clock;

  weight_t wmem [N_WORDS];
  weight_t fmem [N_WORDS];
  int      n_cmp = 0;
  int      n_bad = 0;
  int      edge_cnt = 0;
  int      viol_cnt = 0;
  int      addr_log[$];

  weight_sweep_reader dut (
    .Clock    (Clock),
    .Rst      (Rst),
    .start    (start),
    .ramAddr  (ramAddr),
    .ramRe    (ramRe),
    .ramData  (ramData),
    .featAddr (featAddr),
    .featData (featData),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // Synchronous-read memories; unread cycles return junk so stale data is caught.
  always @(posedge Clock) begin
    edge_cnt <= edge_cnt + 1;
    if (ramRe && int'(ramAddr) < N_WORDS) begin
      ramData  <= wmem[ramAddr];
      featData <= fmem[ramAddr];
    end else begin
      ramData  <= weight_t'($urandom);
      featData <= weight_t'($urandom);
    end
  end

  always @(negedge Clock) begin
    if (ramRe) addr_log.push_back(int'(ramAddr));
    if (featAddr !== ramAddr || int'(ramAddr) >= N_WORDS) viol_cnt <= viol_cnt + 1;
  end

  task automatic check(string name, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic wait_edge();
    @(posedge Clock);
    #1;
  endtask

  function automatic longint expect_out(longint s);
`ifdef WEIGHT_SWEEP_RELU_EN
    return (s < 0) ? 64'sd0 : s;
`else
    return s;
`endif
  endfunction

  function automatic longint ref_sum();
    longint s = 0;
    for (int i = 0; i < N_WORDS; i++) s += longint'(wmem[i]) * longint'(fmem[i]);
    return s;
  endfunction

  task automatic fill_const(int ramp, int w, int f, int f_last);
    for (int i = 0; i < N_WORDS; i++) begin
      wmem[i] = ramp != 0 ? weight_t'(i - N_WORDS / 2) : weight_t'(w);
      fmem[i] = weight_t'(f);
    end
    fmem[N_WORDS-1] = weight_t'(f_last);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N_WORDS; i++) begin
      wmem[i] = weight_t'($urandom_range(0, 1023));
      fmem[i] = weight_t'($urandom_range(0, 1023));
    end
  endtask

  // One full sweep from a start pulse; checks timing, addresses and result.
  task automatic run_sweep(string name, longint exp);
    int   e0, lat, log0, v0, n, addr_err, busy_err, res_chg;
    acc_t res0;
    log0 = addr_log.size();
    v0 = viol_cnt;
    res0 = result;
    lat = -1; addr_err = 0; busy_err = 0; res_chg = 0;
    start = 1'b1;
    wait_edge();
    e0 = edge_cnt;
    start = 1'b0;
    for (int i = 0; i < 200 && lat < 0; i++) begin
      if (done) begin
        lat = edge_cnt - e0;
      end else begin
        if (!busy) busy_err++;
        if (result !== res0) res_chg++;
        wait_edge();
      end
    end
    check({name, " latency"}, lat, N_WORDS + 1);
    check({name, " result"}, longint'(result), exp);
    check({name, " busy_at_done"}, longint'(busy), 0);
    check({name, " busy_during"}, busy_err, 0);
    check({name, " result_stable"}, res_chg, 0);
    n = addr_log.size() - log0;
    for (int j = 0; j < n; j++) if (addr_log[log0 + j] != j) addr_err++;
    check({name, " addr_count"}, n, N_WORDS);
    check({name, " addr_order"}, addr_err, 0);
    check({name, " addr_viol"}, viol_cnt - v0, 0);
    wait_edge();
    check({name, " done_width"}, longint'(done), 0);
  endtask

  typedef struct {
    string  name;
    int     ramp;
    int     w;
    int     f;
    int     f_last;
    longint exp;
  } vec_t;

  vec_t   vecs[6];
  longint exp;
  int     e0, first, done_n, res_bad, a66_re, a66_busy, a67_addr, a67_re;
  int     done_edges[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"ones",    0,    1,    1,    1,        65};
    vecs[1] = '{"max_pos", 0,  511,  511,  511,  16972865};
    vecs[2] = '{"neg",     0, -512,  511,  511, -17006080};
    vecs[3] = '{"neg_neg", 0, -512, -512, -512,  17039360};
    vecs[4] = '{"ramp",    1,    0,    1,    1,         0};
    vecs[5] = '{"ramp_f3", 1,    0,    1,    3,        64};

    Rst = 1'b1;
    start = 1'b0;
    fill_const(0, 0, 0, 0);
    repeat (3) wait_edge();
    check("reset ramAddr", longint'(ramAddr), 0);
    check("reset ramRe", longint'(ramRe), 0);
    check("reset busy", longint'(busy), 0);
    check("reset done", longint'(done), 0);
    check("reset result", longint'(result), 0);
    Rst = 1'b0;
    wait_edge();

    foreach (vecs[v]) begin
      fill_const(vecs[v].ramp, vecs[v].w, vecs[v].f, vecs[v].f_last);
      run_sweep(vecs[v].name, expect_out(vecs[v].exp));
      wait_edge();
    end

    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_sweep($sformatf("rand%0d", r), expect_out(ref_sum()));
    end

    // Extra start at edge 10 must not restart or queue a sweep.
    fill_const(0, 3, 2, 2);
    start = 1'b1;
    wait_edge();
    e0 = edge_cnt;
    first = -1; done_n = 0;
    for (int k = 1; k <= 150; k++) begin
      start = (k == 10);
      wait_edge();
      if (done) begin
        done_n++;
        if (first < 0) first = edge_cnt - e0;
      end
    end
    start = 1'b0;
    check("midstart done_edge", first, N_WORDS + 1);
    check("midstart done_count", done_n, 1);
    check("midstart result", longint'(result), 390);

    // Reset at edge 30 of a sweep.
    start = 1'b1;
    wait_edge();
    start = 1'b0;
    for (int k = 1; k < 30; k++) wait_edge();
    Rst = 1'b1;
    wait_edge();
    Rst = 1'b0;
    check("rst ramAddr", longint'(ramAddr), 0);
    check("rst ramRe", longint'(ramRe), 0);
    check("rst busy", longint'(busy), 0);
    check("rst result", longint'(result), 0);
    done_n = 0;
    for (int k = 0; k < 100; k++) begin
      if (done) done_n++;
      wait_edge();
    end
    check("rst no_done", done_n, 0);
    fill_random();
    run_sweep("after_rst", expect_out(ref_sum()));

    // Start held high: back-to-back sweeps with one idle cycle between.
    fill_random();
    exp = expect_out(ref_sum());
    start = 1'b1;
    wait_edge();
    res_bad = 0; a66_re = -1; a66_busy = -1; a67_addr = -1; a67_re = -1;
    for (int k = 1; k <= 260; k++) begin
      if (k == 200) start = 1'b0;
      wait_edge();
      if (done) begin
        done_edges.push_back(k);
        if (result !== acc_t'(exp)) res_bad++;
      end
      if (k == 66) begin
        a66_re = int'(ramRe);
        a66_busy = int'(busy);
      end
      if (k == 67) begin
        a67_addr = int'(ramAddr);
        a67_re = int'(ramRe);
      end
    end
    check("held done_count", done_edges.size(), 3);
    check("held done0", done_edges.size() > 0 ? done_edges[0] : -1, 66);
    check("held done1", done_edges.size() > 1 ? done_edges[1] : -1, 133);
    check("held done2", done_edges.size() > 2 ? done_edges[2] : -1, 200);
    check("held results", res_bad, 0);
    check("held idle_re", a66_re, 0);
    check("held idle_busy", a66_busy, 0);
    check("held restart_addr", a67_addr, 0);
    check("held restart_re", a67_re, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
